mpu_i2c_responder: RTL

MPU_I2C_RESPONDER -- requirements
Module: mpu_i2c_responder

---
 rtl/mpu_i2c_responder.sv | 275 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/mpu_i2c_responder.sv
// rtl/mpu_i2c_responder.sv - I2C target serving gyro samples and a small register map
// Define MPU_I2C_RESPONDER_GLITCH_FILTER_EN to require 4 equal samples per line change.
module mpu_i2c_responder #(
  parameter logic [6:0] DEV_ADDR = 7'h68,
  parameter logic [7:0] WHO_AM_I = 8'h68
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe_out,
  input  logic [15:0] gx_in,
  input  logic [15:0] gy_in,
  input  logic [15:0] gz_in,
  output logic        busy_out,
  output logic        wr_valid_out,
  output logic [7:0]  wr_addr_out,
  output logic [7:0]  wr_data_out
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_PTR, ST_PTR_ACK,
    ST_WDATA, ST_WDATA_ACK, ST_RDATA, ST_RDATA_ACK
  } state_t;

  logic [1:0] r_scl_sync, r_sda_sync;
  logic       w_scl, w_sda, r_scl_q, r_sda_q;
  logic       w_scl_rise, w_scl_fall, w_start, w_stop;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
    end else begin
      r_scl_sync <= {r_scl_sync[0], scl_in};
      r_sda_sync <= {r_sda_sync[0], sda_in};
    end
  end

`ifdef MPU_I2C_RESPONDER_GLITCH_FILTER_EN
  logic [2:0] r_scl_hist, r_sda_hist;
  logic       r_scl_filt, r_sda_filt;
  logic [3:0] w_scl_run, w_sda_run;

  assign w_scl_run = {r_scl_hist, r_scl_sync[1]};
  assign w_sda_run = {r_sda_hist, r_sda_sync[1]};

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_scl_hist <= 3'b111;
      r_sda_hist <= 3'b111;
      r_scl_filt <= 1'b1;
      r_sda_filt <= 1'b1;
    end else begin
      r_scl_hist <= w_scl_run[2:0];
      r_sda_hist <= w_sda_run[2:0];
      if (&w_scl_run)       r_scl_filt <= 1'b1;
      else if (~|w_scl_run) r_scl_filt <= 1'b0;
      if (&w_sda_run)       r_sda_filt <= 1'b1;
      else if (~|w_sda_run) r_sda_filt <= 1'b0;
    end
  end

  assign w_scl = r_scl_filt;
  assign w_sda = r_sda_filt;
`else
  assign w_scl = r_scl_sync[1];
  assign w_sda = r_sda_sync[1];
`endif

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_scl_q <= 1'b1;
      r_sda_q <= 1'b1;
    end else begin
      r_scl_q <= w_scl;
      r_sda_q <= w_sda;
    end
  end

  assign w_scl_rise = w_scl & ~r_scl_q;
  assign w_scl_fall = ~w_scl & r_scl_q;
  assign w_start    = r_scl_q & w_scl & r_sda_q & ~w_sda;
  assign w_stop     = r_scl_q & w_scl & ~r_sda_q & w_sda;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [7:0]  r_shift, w_shift_nxt;
  logic [7:0]  r_tx, w_tx_nxt;
  logic [7:0]  r_ptr, w_ptr_nxt;
  logic [7:0]  r_pwr, w_pwr_nxt;
  logic        r_rw, w_rw_nxt;
  logic        r_sda_oe, w_sda_oe_nxt;
  logic        r_busy, w_busy_nxt;
  logic        r_wr_valid, w_wr_valid_nxt;
  logic [7:0]  r_wr_addr, w_wr_addr_nxt;
  logic [7:0]  r_wr_data, w_wr_data_nxt;
  logic        w_snap;
  logic [15:0] r_gx, r_gy, r_gz;
  logic [7:0]  w_rd_addr, w_rd_byte;

  // The byte about to be loaded: current pointer on read entry, pointer+1 after an ACK.
  always_comb begin
    w_rd_addr = (r_state == ST_RDATA_ACK) ? r_ptr + 8'd1 : r_ptr;
    w_rd_byte = 8'h00;
    case (w_rd_addr)
      8'h43:   w_rd_byte = r_gx[15:8];
      8'h44:   w_rd_byte = r_gx[7:0];
      8'h45:   w_rd_byte = r_gy[15:8];
      8'h46:   w_rd_byte = r_gy[7:0];
      8'h47:   w_rd_byte = r_gz[15:8];
      8'h48:   w_rd_byte = r_gz[7:0];
      8'h6B:   w_rd_byte = r_pwr;
      8'h75:   w_rd_byte = WHO_AM_I;
      default: w_rd_byte = 8'h00;
    endcase
    if (r_pwr[6] && (w_rd_addr >= 8'h43) && (w_rd_addr <= 8'h48)) w_rd_byte = 8'h00;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_shift_nxt    = r_shift;
    w_tx_nxt       = r_tx;
    w_ptr_nxt      = r_ptr;
    w_pwr_nxt      = r_pwr;
    w_rw_nxt       = r_rw;
    w_sda_oe_nxt   = r_sda_oe;
    w_busy_nxt     = r_busy;
    w_wr_valid_nxt = 1'b0;
    w_wr_addr_nxt  = r_wr_addr;
    w_wr_data_nxt  = r_wr_data;
    w_snap         = 1'b0;
    if (w_stop) begin
      w_state_nxt  = ST_IDLE;
      w_sda_oe_nxt = 1'b0;
      w_busy_nxt   = 1'b0;
    end else if (w_start) begin
      w_state_nxt  = ST_ADDR;
      w_cnt_nxt    = 4'd0;
      w_sda_oe_nxt = 1'b0;
      w_busy_nxt   = 1'b0;
    end else begin
      case (r_state)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (w_scl_rise && (r_cnt < 4'd8)) begin
            w_shift_nxt = {r_shift[6:0], w_sda};
            w_cnt_nxt   = r_cnt + 4'd1;
          end else if (w_scl_fall && (r_cnt == 4'd8)) begin
            if (r_state == ST_ADDR) begin
              if (r_shift[7:1] == DEV_ADDR) begin
                w_sda_oe_nxt = 1'b1;
                w_busy_nxt   = 1'b1;
                w_rw_nxt     = r_shift[0];
                w_snap       = r_shift[0];
                w_state_nxt  = ST_ADDR_ACK;
              end else begin
                w_state_nxt = ST_IDLE;
              end
            end else if (r_state == ST_PTR) begin
              w_ptr_nxt    = r_shift;
              w_sda_oe_nxt = 1'b1;
              w_state_nxt  = ST_PTR_ACK;
            end else begin
              w_sda_oe_nxt   = 1'b1;
              w_wr_valid_nxt = 1'b1;
              w_wr_addr_nxt  = r_ptr;
              w_wr_data_nxt  = r_shift;
              if (r_ptr == 8'h6B) w_pwr_nxt = r_shift;
              w_ptr_nxt      = r_ptr + 8'd1;
              w_state_nxt    = ST_WDATA_ACK;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (w_scl_fall) begin
            w_cnt_nxt = 4'd0;
            if (r_rw) begin
              w_tx_nxt     = w_rd_byte;
              w_sda_oe_nxt = ~w_rd_byte[7];
              w_state_nxt  = ST_RDATA;
            end else begin
              w_sda_oe_nxt = 1'b0;
              w_state_nxt  = ST_PTR;
            end
          end
        end
        ST_PTR_ACK, ST_WDATA_ACK: begin
          if (w_scl_fall) begin
            w_sda_oe_nxt = 1'b0;
            w_cnt_nxt    = 4'd0;
            w_state_nxt  = ST_WDATA;
          end
        end
        ST_RDATA: begin
          if (w_scl_rise && (r_cnt < 4'd8)) begin
            w_cnt_nxt = r_cnt + 4'd1;
          end else if (w_scl_fall) begin
            if (r_cnt == 4'd8) begin
              w_sda_oe_nxt = 1'b0;
              w_state_nxt  = ST_RDATA_ACK;
            end else begin
              w_tx_nxt     = {r_tx[6:0], 1'b0};
              w_sda_oe_nxt = ~r_tx[6];
            end
          end
        end
        ST_RDATA_ACK: begin
          if (w_scl_rise) begin
            w_shift_nxt = {r_shift[6:0], w_sda};
          end else if (w_scl_fall) begin
            if (!r_shift[0]) begin
              w_ptr_nxt    = r_ptr + 8'd1;
              w_tx_nxt     = w_rd_byte;
              w_sda_oe_nxt = ~w_rd_byte[7];
              w_cnt_nxt    = 4'd0;
              w_state_nxt  = ST_RDATA;
            end else begin
              w_sda_oe_nxt = 1'b0;
              w_state_nxt  = ST_IDLE;
            end
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 4'd0;
      r_shift    <= 8'h00;
      r_tx       <= 8'h00;
      r_ptr      <= 8'h00;
      r_pwr      <= 8'h40;
      r_rw       <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_busy     <= 1'b0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= 8'h00;
      r_wr_data  <= 8'h00;
      r_gx       <= 16'h0000;
      r_gy       <= 16'h0000;
      r_gz       <= 16'h0000;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_tx       <= w_tx_nxt;
      r_ptr      <= w_ptr_nxt;
      r_pwr      <= w_pwr_nxt;
      r_rw       <= w_rw_nxt;
      r_sda_oe   <= w_sda_oe_nxt;
      r_busy     <= w_busy_nxt;
      r_wr_valid <= w_wr_valid_nxt;
      r_wr_addr  <= w_wr_addr_nxt;
      r_wr_data  <= w_wr_data_nxt;
      if (w_snap) begin
        r_gx <= gx_in;
        r_gy <= gy_in;
        r_gz <= gz_in;
      end
    end
  end

  assign sda_oe_out   = r_sda_oe;
  assign busy_out     = r_busy;
  assign wr_valid_out = r_wr_valid;
  assign wr_addr_out  = r_wr_addr;
  assign wr_data_out  = r_wr_data;

endmodule
